sample_requantizer: RTL and testbench
=====================================

SAMPLE_REQUANTIZER -- requirements
Module: sample_requantizer

Interface
REQ-001 SHALL have parameter IN_W, default 24: input sample width in bits, range 2..32.
REQ-002 SHALL have parameter OUT_W, default 8: output sample width in bits, range 2..32.
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO entries, power of two, at least 2.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 enn  input  1  block enable; low = flush and hold idle.
REQ-007 in_valid  input  1  in_data holds a sample.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 in_data  input  IN_W  two's-complement input sample.
REQ-010 out_valid  output  1  out_data holds the FIFO head.
REQ-011 out_ready  input  1  consumer takes the head this cycle.
REQ-012 out_data  output  OUT_W  two's-complement requantized sample.
REQ-013 level  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-014 sat_cnt  output  8  saturation event count (see Configuration).

Function
REQ-015 Accept on an edge where in_valid and in_ready are both high; push the converted sample into the FIFO on that edge.
REQ-016 in_ready SHALL be high iff enn high and level < DEPTH, independent of out_ready.
REQ-017 Pop on an edge where out_valid and out_ready are both high; out_valid SHALL be high iff level > 0; out_data SHALL show the head (show-ahead); out_data is don't-care while out_valid is low.
REQ-018 Latency: a sample accepted at edge N into an empty FIFO SHALL appear on out_data with out_valid high in the cycle after edge N.
REQ-019 Simultaneous push and pop SHALL leave level unchanged and preserve order; push when full is impossible because in_ready is low; pop when empty is ignored.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH.
REQ-021 Down-conversion (IN_W > OUT_W), shift S = IN_W-OUT_W: sign-preserving arithmetic right shift by S, with rounding per REQ-028.
REQ-022 Up-conversion (IN_W < OUT_W): sign-extend, then left shift by OUT_W-IN_W, with zero-filled LSBs.
REQ-023 Equal widths: pass through unchanged; never saturates.
REQ-024 enn low at an edge SHALL synchronously empty the FIFO (level 0, pointers 0) and ignore out_ready; sat_cnt is retained.

Reset
REQ-025 rst_n low SHALL asynchronously clear pointers, level, sat_cnt and all FIFO storage to 0.
REQ-026 During reset, in_ready=0, out_valid=0, out_data=0, level=0 and sat_cnt=0.
REQ-027 Reset asserted mid-transfer SHALL discard all buffered samples; the first accept after release occurs no earlier than the first edge with rst_n high and enn high.

Configuration
REQ-028 With macro REQUANT_ROUND_EN defined, down-conversion SHALL add 2^(S-1) before the shift, compute in IN_W+1 bits and saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-029 With REQUANT_ROUND_EN defined, each accepted sample that saturates SHALL increment sat_cnt by 1, holding at 255.
REQ-030 Without REQUANT_ROUND_EN, down-conversion SHALL truncate (floor) with no saturation logic, and sat_cnt SHALL be tied to 0.

Verification
REQ-031 Defaults, macro on: push 24'h128000 -> out_data 8'h13; push 24'hFF8000 -> 8'h00; macro off: same pushes -> 8'h12 and 8'hFF.
REQ-032 Macro on: push 24'h7FFFFF -> out_data 8'h7F, sat_cnt 1; macro off -> 8'h7F, sat_cnt 0.
REQ-033 out_ready=0, push 24'h010000, 24'h020000, 24'h030000, 24'h040000 -> level 4, in_ready 0; 5th sample held; set out_ready=1 -> outputs 8'h01..8'h04 in order, one per cycle.
REQ-034 Level 2, push and pop on the same edge -> level stays 2, order preserved; pointers wrap across at least 3 full DEPTH cycles with no loss.
REQ-035 Level 3, enn low for one edge -> level 0, out_valid 0; sat_cnt unchanged. Level 3, rst_n pulsed low between edges -> outputs cleared immediately, before the next edge.
REQ-036 IN_W=8, OUT_W=16: push 8'h80 -> out_data 16'h8000; push 8'h01 -> 16'h0100; sat_cnt stays 0.

Source files
------------

// File: rtl/sample_requantizer.sv
// rtl/sample_requantizer.sv - sample width converter with show-ahead output FIFO (optional macro REQUANT_ROUND_EN: round + saturate on down-conversion)
module sample_requantizer #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [7:0]                   sat_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OUT_W-1:0] conv_data;
    logic             conv_sat;
    logic             push;
    logic             pop;

    // Handshake: ready is forced low while reset is asserted so nothing is taken in reset.
    assign in_ready  = rst_n && enn && (level < LW'(DEPTH));
    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    generate
        if (IN_W > OUT_W) begin : g_down
            localparam int S = IN_W - OUT_W;
`ifdef REQUANT_ROUND_EN
            localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (S-1);
            logic [IN_W:0] rnd_sum;
            logic [IN_W:0] rnd_shf;
            logic          unused_shf;
            // One extra bit keeps the rounding add from wrapping at the positive limit.
            assign rnd_sum   = {in_data[IN_W-1], in_data} + HALF;
            assign rnd_shf   = $signed(rnd_sum) >>> S;
            // The shifted value fits OUT_W+1 bits; differing top bits mean it left the output range.
            assign conv_sat  = rnd_shf[OUT_W] ^ rnd_shf[OUT_W-1];
            assign conv_data = !conv_sat ? rnd_shf[OUT_W-1:0] :
                               (rnd_shf[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                               : {1'b0, {(OUT_W-1){1'b1}}});
            assign unused_shf = ^rnd_shf[IN_W:OUT_W+1];
`else
            logic unused_low;
            // Keeping the top bits is an arithmetic shift with floor rounding.
            assign conv_data  = in_data[IN_W-1:S];
            assign conv_sat   = 1'b0;
            assign unused_low = ^in_data[S-1:0];
`endif
        end else if (IN_W < OUT_W) begin : g_up
            // Sign extension followed by a left shift leaves the input in the top bits.
            assign conv_data = {in_data, {(OUT_W-IN_W){1'b0}}};
            assign conv_sat  = 1'b0;
        end else begin : g_same
            assign conv_data = in_data;
            assign conv_sat  = 1'b0;
        end
    endgenerate

    // FIFO storage, pointers and occupancy; enn low empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!enn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= conv_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef REQUANT_ROUND_EN
    // Saturation event counter, sticky at its maximum and kept across flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= 8'd0;
        end else if (push && conv_sat && (sat_cnt != 8'hFF)) begin
            sat_cnt <= sat_cnt + 8'd1;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = conv_sat;
    assign sat_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_sample_requantizer.sv
// tb/tb_sample_requantizer.sv - randomized and directed checks of sample_requantizer against a reference model
module tb_sample_requantizer;

    localparam int IN_W  = 24;
    localparam int OUT_W = 8;
    localparam int DEPTH = 4;
`ifdef REQUANT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enn;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [2:0]        level;
    logic [7:0]        sat_cnt;

    logic              up_enn;
    logic              up_in_valid;
    logic              up_in_ready;
    logic [7:0]        up_in_data;
    logic              up_out_valid;
    logic              up_out_ready;
    logic [15:0]       up_out_data;
    logic [2:0]        up_level;
    logic [7:0]        up_sat_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] q[$];
    int exp_sat = 0;

    always #5 clk = ~clk;

    sample_requantizer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .enn(enn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .sat_cnt(sat_cnt)
    );

    sample_requantizer #(.IN_W(8), .OUT_W(16), .DEPTH(4)) u_up (
        .clk(clk), .rst_n(rst_n), .enn(up_enn),
        .in_valid(up_in_valid), .in_ready(up_in_ready), .in_data(up_in_data),
        .out_valid(up_out_valid), .out_ready(up_out_ready), .out_data(up_out_data),
        .level(up_level), .sat_cnt(up_sat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint qq;
        qq = a / b;
        if ((a % b != 0) && (a < 0)) qq = qq - 1;
        return qq;
    endfunction

    // Numeric meaning of the conversion: value scaled by 2^(ow-iw), rounded or floored, clamped.
    function automatic logic [31:0] model_conv(input longint raw, input int iw, input int ow,
                                               output bit sat);
        longint v;
        longint r;
        v   = raw[iw-1] ? raw - (longint'(1) << iw) : raw;
        sat = 1'b0;
        if (iw > ow) begin
`ifdef REQUANT_ROUND_EN
            longint hi;
            longint lo;
            hi = (longint'(1) << (ow-1)) - 1;
            lo = -(longint'(1) << (ow-1));
            r  = floor_div(v + (longint'(1) << (iw-ow-1)), longint'(1) << (iw-ow));
            if (r > hi) begin r = hi; sat = 1'b1; end
            else if (r < lo) begin r = lo; sat = 1'b1; end
`else
            r = floor_div(v, longint'(1) << (iw-ow));
`endif
        end else begin
            r = v * (longint'(1) << (ow-iw));
        end
        return 32'(r & ((longint'(1) << ow) - 1));
    endfunction

    // One clock: drive inputs, check outputs against the model, advance the model with the edge.
    task automatic step(input bit v, input logic [IN_W-1:0] d, input bit r, input bit e);
        logic [31:0] cv;
        bit st;
        bit acc;
        bit pp;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        enn       = e;
        @(negedge clk);
        chk("in_ready", in_ready, (e && q.size() < DEPTH));
        chk("out_valid", out_valid, q.size() > 0);
        chk("level", level, q.size());
        if (q.size() > 0) chk("out_data", out_data, q[0]);
        chk("sat_cnt", sat_cnt, exp_sat);
        acc = v && e && (q.size() < DEPTH);
        pp  = r && (q.size() > 0);
        cv  = model_conv(longint'(d), IN_W, OUT_W, st);
        if (!e) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(cv);
                if (st && exp_sat < 255) exp_sat++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit dummy;
        logic [IN_W-1:0] rd;
        rst_n = 1'b0; enn = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        up_enn = 1'b1; up_in_valid = 1'b0; up_in_data = '0; up_out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", level, 0);
        chk("rst_sat", sat_cnt, 0);
        chk("rst_up_in_ready", up_in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Up-conversion instance
        up_in_valid = 1'b1; up_in_data = 8'h80;
        @(posedge clk); #1;
        up_in_valid = 1'b0;
        chk("up_valid", up_out_valid, 1);
        chk("up_neg", up_out_data, 16'h8000);
        chk("up_neg_model", up_out_data, model_conv(64'h80, 8, 16, dummy));
        up_out_ready = 1'b1;
        @(posedge clk); #1;
        up_out_ready = 1'b0; up_in_valid = 1'b1; up_in_data = 8'h01;
        @(posedge clk); #1;
        up_in_valid = 1'b0;
        chk("up_pos", up_out_data, 16'h0100);
        chk("up_level", up_level, 1);
        chk("up_sat", up_sat_cnt, 0);

        // Rounding / truncation and latency into an empty FIFO
        step(1, 24'h128000, 0, 1);
        chk("latency", out_valid, 1);
        chk("conv_pos", out_data, ROUND ? 8'h13 : 8'h12);
        step(0, '0, 1, 1);
        step(1, 24'hFF8000, 0, 1);
        chk("conv_neg", out_data, ROUND ? 8'h00 : 8'hFF);
        step(0, '0, 1, 1);
        step(1, 24'h7FFFFF, 0, 1);
        chk("sat_data", out_data, 8'h7F);
        chk("sat_one", sat_cnt, ROUND ? 1 : 0);
        step(0, '0, 1, 1);

        // Fill to full, hold a fifth sample, then drain in order
        for (int i = 1; i <= 4; i++) step(1, 24'(i << 16), 0, 1);
        chk("full_level", level, 4);
        chk("full_ready", in_ready, 0);
        step(1, 24'h050000, 0, 1);
        step(1, 24'h050000, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", out_data, i);
            step(0, '0, 1, 1);
        end
        chk("drain_empty", out_valid, 0);

        // Simultaneous push and pop at level 2, then many wraps
        step(1, 24'h0A0000, 0, 1);
        step(1, 24'h0B0000, 0, 1);
        step(1, 24'h0C0000, 1, 1);
        chk("pp_level", level, 2);
        chk("pp_head", out_data, 8'h0B);
        for (int i = 0; i < 4 * DEPTH; i++) step(1, 24'($urandom), 1, 1);
        step(0, '0, 1, 1);
        step(0, '0, 1, 1);

        // Flush with enn low at level 3
        for (int i = 0; i < 3; i++) step(1, 24'h7FFFFF, 0, 1);
        chk("pre_flush_level", level, 3);
        step(0, '0, 1, 0);
        chk("flush_level", level, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_sat", sat_cnt, ROUND ? 4 : 0);

        // Asynchronous reset between edges at level 3
        for (int i = 0; i < 3; i++) step(1, 24'h300000, 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_sat", sat_cnt, 0);
        q.delete();
        exp_sat = 0;
        #1;
        rst_n = 1'b1;
        step(1, 24'h020000, 0, 1);
        chk("post_rst_data", out_data, 8'h02);
        step(0, '0, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom % 4)
                0:       rd = 24'h7FFFFF;
                1:       rd = 24'h800000;
                2:       rd = 24'h7F8000;
                default: rd = 24'($urandom);
            endcase
            step($urandom_range(0, 9) < 7, rd, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) != 0);
        end

        // Counter holds at its maximum
        for (int i = 0; i < 300; i++) step(1, 24'h7FFFFF, 1, 1);
        chk("sat_hold", sat_cnt, ROUND ? 255 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
